// File: rtl/seq_mdu_core_if.sv
// Request/result bundle for seq_mdu_core: operation strobe, operands, status and HI/LO.
interface seq_mdu_core_if;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, ctrl, srcA, srcB,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, ctrl, srcA, srcB,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/seq_mdu_core.sv
// Sequential 32-bit multiply/divide unit: 32 iteration cycles plus one sign-fix cycle.
// Optional MDU_DIVZERO_KEEP_EN: a div/divu with a zero divisor is dropped instead of executed.
module seq_mdu_core (
    input logic           clk,
    input logic           reset,
    seq_mdu_core_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

`ifdef MDU_DIVZERO_KEEP_EN
    localparam bit DivZeroKeep = 1'b1;
`else
    localparam bit DivZeroKeep = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Request decode
    logic        req_muldiv;
    logic        req_div;
    logic        req_signed;
    logic        req_accept;
    logic [31:0] src_a_mag;

    always_comb begin
        req_muldiv = (bus.ctrl == OpMult) || (bus.ctrl == OpMultu) ||
                     (bus.ctrl == OpDiv)  || (bus.ctrl == OpDivu);
        req_div    = (bus.ctrl == OpDiv)  || (bus.ctrl == OpDivu);
        req_signed = (bus.ctrl == OpMult) || (bus.ctrl == OpDiv);
        req_accept = bus.start && req_muldiv &&
                     !(DivZeroKeep && req_div && (bus.srcB == 32'd0));
        src_a_mag  = (req_signed && bus.srcA[31]) ? -bus.srcA : bus.srcA;
    end

    // Latched operation flags and divisor/multiplier magnitude
    logic        op_signed;
    logic        op_div;
    logic [31:0] b_mag;

    always_comb begin
        op_signed = (op_q == OpMult) || (op_q == OpDiv);
        op_div    = (op_q == OpDiv)  || (op_q == OpDivu);
        b_mag     = (op_signed && b_q[31]) ? -b_q : b_q;
    end

    // One shift-add multiply step: work = {product_hi, multiplier bits still to consume}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_mag} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};
    end

    // One restoring divide step: work = {partial remainder, dividend/quotient bits}
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_next;

    always_comb begin
        div_shift = {work_q[63:32], work_q[31]};
        div_trial = div_shift - {1'b0, b_mag};
        if (div_trial[32]) begin
            div_next = {div_shift[31:0], work_q[30:0], 1'b0};
        end else begin
            div_next = {div_trial[31:0], work_q[30:0], 1'b1};
        end
    end

    // Sign correction applied in the fix cycle
    logic        a_neg;
    logic        b_neg;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        a_neg    = op_signed && a_q[31];
        b_neg    = op_signed && b_q[31];
        prod_fix = (a_neg ^ b_neg) ? -work_q : work_q;
        quo_fix  = (a_neg ^ b_neg) ? -work_q[31:0] : work_q[31:0];
        rem_fix  = a_neg ? -work_q[63:32] : work_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_accept) begin
                    state_d = StRun;
                    op_d    = bus.ctrl;
                    a_d     = bus.srcA;
                    b_d     = bus.srcB;
                    work_d  = {32'd0, src_a_mag};
                    cnt_d   = 5'd0;
                end else if (bus.start && (bus.ctrl == OpMthi)) begin
                    hi_d = bus.srcA;
                end else if (bus.start && (bus.ctrl == OpMtlo)) begin
                    lo_d = bus.srcA;
                end
            end
            StRun: begin
                work_d = op_div ? div_next : mul_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!op_div) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (b_q == 32'd0) begin
                    // Zero divisor: all-ones quotient, dividend passed through as remainder
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            work_q  <= 64'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: doc/seq_mdu_core.md
SEQ_MDU_CORE -- requirements
Module: seq_mdu_core

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 ctrl  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-15 none.
REQ-006 srcA  input  32  multiplicand / dividend / mthi-mtlo data.
REQ-007 srcB  input  32  multiplier / divisor.
REQ-008 busy  output  1  high while a multiply/divide is in flight.
REQ-009 done  output  1  one-cycle pulse when a new result becomes visible on HI/LO.
REQ-010 HI  output  32  high product word / remainder.
REQ-011 LO  output  32  low product word / quotient.

Function
REQ-012 SHALL implement the states IDLE, RUN and FIX.
REQ-013 IDLE->RUN at a clk edge with start=1, busy=0 and ctrl in 1-4; operands and ctrl are latched on that edge.
REQ-014 RUN SHALL perform exactly 32 iterations (unsigned shift-add multiply or restoring divide on operand magnitudes), one per cycle, then go to FIX.
REQ-015 FIX SHALL apply signs for mult/div, write HI/LO, and go to IDLE after 1 cycle.
REQ-016 busy SHALL be 1 in RUN and FIX, i.e. exactly 33 cycles after the accepting edge.
REQ-017 HI/LO SHALL hold their previous values throughout RUN/FIX; new values appear on the edge leaving FIX.
REQ-018 done SHALL be 1 for exactly the first IDLE cycle after FIX, else 0.
REQ-019 mult/multu: {HI,LO} = 64-bit signed/unsigned product of srcA, srcB.
REQ-020 div/divu: LO = quotient truncated toward zero, HI = remainder with dividend's sign (signed) or unsigned.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi/mtlo with start=1, busy=0: HI (resp. LO) <= srcA on that edge; busy stays 0; done stays 0.
REQ-023 start while busy=1 SHALL be ignored entirely (no latch, no state change).
REQ-024 start with ctrl 0 or 7-15 SHALL be ignored.
REQ-025 srcA/srcB/ctrl changes after the accepting edge SHALL NOT affect the running operation.
REQ-026 start in the done cycle SHALL be accepted normally (back-to-back operations).

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, busy=0, done=0, HI=0, LO=0, all internal operand/iteration registers 0.
REQ-028 reset asserted mid-RUN/FIX SHALL abort the operation with no HI/LO update after release.
REQ-029 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-030 Macro MDU_DIVZERO_KEEP_EN.
REQ-031 Defined: div/divu with srcB=0 SHALL be ignored (no busy, no done, HI/LO unchanged).
REQ-032 Not defined: div/divu with srcB=0 SHALL run the full 33 cycles and write LO=0xFFFFFFFF, HI=srcA, with done pulse.

Verification
REQ-033 Reset release, start=1 ctrl=1 srcA=0xFFFFFFFE srcB=3 -> busy 33 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA, done 1 cycle.
REQ-034 ctrl=3 srcA=0xFFFFFFF9 (-7) srcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; ctrl=4 same operands -> LO=0x7FFFFFFC, HI=1.
REQ-035 ctrl=2 srcA=srcB=0xFFFFFFFF, start pulsed again at cycle 10 with ctrl=5 -> second start ignored; HI=0xFFFFFFFE LO=1.
REQ-036 ctrl=4 srcB=0, srcA=0x1234 -> with MDU_DIVZERO_KEEP_EN: busy stays 0, HI/LO unchanged; without: after 33 cycles LO=0xFFFFFFFF HI=0x1234.
REQ-037 mult started, reset=0 at RUN cycle 15 for 2 cycles -> busy=0, HI=LO=0 immediately; no done after release; then ctrl=6 srcA=0xA5A5A5A5 -> LO=0xA5A5A5A5 next edge, busy 0.
